// File: rtl/core_if_pc_gen_if.sv
// Fetch-unit bundle: imem request/response handshakes + decode handshake.
// master = fetch unit; slave = memory/decode side.
interface core_if_pc_gen_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [PC_WIDTH-1:0]   imem_req_addr;
  logic                  imem_rsp_valid;
  logic                  imem_rsp_ready;
  logic [INST_WIDTH-1:0] imem_rsp_inst;
  logic                  if_valid;
  logic                  if_ready;
  logic [INST_WIDTH-1:0] if_inst;
  logic [PC_WIDTH-1:0]   if_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output imem_rsp_ready,
    output if_valid,
    output if_inst,
    output if_pc,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_inst,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  imem_rsp_ready,
    input  if_valid,
    input  if_inst,
    input  if_pc,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_inst,
    output if_ready
  );
endinterface

// File: rtl/core_if_pc_gen.sv
// Fetch PC generator with one outstanding imem request and a 1-entry
// buffer to decode; EX redirects squash in-flight/buffered wrong-path words.
// Ports: clk, rst (async, active high), ex_redirect, ex_redirect_pc,
//   bus (core_if_pc_gen_if.master: imem req/rsp, if_valid/ready/inst/pc).
// Option: CORE_IF_REDIRECT_CNT_EN adds 32-bit if_redirect_cnt output.
module core_if_pc_gen #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(32'h8000_0000),
  parameter int unsigned         INST_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_redirect,
  input  logic [PC_WIDTH-1:0] ex_redirect_pc,
`ifdef CORE_IF_REDIRECT_CNT_EN
  output logic [31:0]         if_redirect_cnt,
`endif
  core_if_pc_gen_if.master    bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic                  kill_q, kill_d;
  logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
  logic [PC_WIDTH-1:0]   if_pc_q, if_pc_d;

  logic [PC_WIDTH-1:0]   tgt;
  logic                  req_fire;
  logic                  rsp_fire;

  // JALR targets may carry bit 0 set; fetch ignores it.
  assign tgt = {ex_redirect_pc[PC_WIDTH-1:1], 1'b0};

  // A redirect withdraws the request in the same cycle; rst gating keeps
  // the request low while the state register is held in S_REQ by reset.
  assign bus.imem_req_valid = (state_q == S_REQ)
                            & ~ex_redirect & ~rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.imem_rsp_ready = (state_q == S_WAIT);
  assign bus.if_valid       = (state_q == S_OUT) & ~ex_redirect;
  assign bus.if_inst        = if_inst_q;
  assign bus.if_pc          = if_pc_q;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_ready & bus.imem_rsp_valid;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    kill_d    = kill_q;
    if_inst_d = if_inst_q;
    if_pc_d   = if_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (ex_redirect) begin
          pc_d = tgt;
        end else if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_WIDTH'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ex_redirect) begin
          pc_d = tgt;
        end
        if (rsp_fire) begin
          if (kill_q | ex_redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_inst_d = bus.imem_rsp_inst;
            if_pc_d   = req_pc_q;
            state_d   = S_OUT;
          end
        end else if (ex_redirect) begin
          // Word still owed by memory belongs to the wrong path.
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (ex_redirect) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (bus.if_ready) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      kill_q    <= 1'b0;
      if_inst_q <= '0;
      if_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      kill_q    <= kill_d;
      if_inst_q <= if_inst_d;
      if_pc_q   <= if_pc_d;
    end
  end

`ifdef CORE_IF_REDIRECT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {31'd0, ex_redirect};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign if_redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_core_if_pc_gen.sv
// Randomized bench for core_if_pc_gen against a program-order fetch model.
// Second instance covers the wrapping reset PC and async reset mid-fetch.
module tb_core_if_pc_gen;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_redirect2;
  logic [31:0] ex_redirect_pc2;
`ifdef CORE_IF_REDIRECT_CNT_EN
  logic [31:0] cnt;
  logic [31:0] cnt2;
`endif

  core_if_pc_gen_if bus ();
  core_if_pc_gen_if bus2 ();

  always #5 clk = ~clk;

  core_if_pc_gen #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc),
`ifdef CORE_IF_REDIRECT_CNT_EN
    .if_redirect_cnt(cnt),
`endif
    .bus            (bus.master)
  );

  core_if_pc_gen #(
    .RESET_PC(RST_PC2)
  ) dut2 (
    .clk            (clk),
    .rst            (rst2),
    .ex_redirect    (ex_redirect2),
    .ex_redirect_pc (ex_redirect_pc2),
`ifdef CORE_IF_REDIRECT_CNT_EN
    .if_redirect_cnt(cnt2),
`endif
    .bus            (bus2.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // stimulus knobs (percent / max latency)
  int p_rdy, lat_max, p_ifr, p_redir;

  // reference model: next in-order PC decode should see
  logic [31:0] exp_pc;
  bit          pend;
  int          dly;
  logic [31:0] pend_addr;
  int          deliv;
  logic [31:0] cnt_m;
  bit          chk_lat;
  logic [31:0] lat_tgt;
  bit          hold_chk;
  logic [31:0] hold_pc, hold_inst;

  task automatic model_reset();
    exp_pc   = RST_PC;
    pend     = 1'b0;
    dly      = 0;
    cnt_m    = '0;
    chk_lat  = 1'b0;
    hold_chk = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst                = 1'b1;
    ex_redirect        = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.if_ready       = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_rsp_ready", bus.imem_rsp_ready, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    bit rv, rr, qv, qr, iv, ir;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      bus.imem_req_ready = ($urandom_range(99) < p_rdy);
      bus.imem_rsp_valid = pend && (dly == 0);
      bus.imem_rsp_inst  = (pend && dly == 0) ?
                           mem_word(pend_addr) : $urandom;
      bus.if_ready       = ($urandom_range(99) < p_ifr);
      ex_redirect        = ($urandom_range(99) < p_redir);
      ex_redirect_pc     = $urandom;
      #5;
      rv = bus.imem_rsp_valid;
      rr = bus.imem_rsp_ready;
      qv = bus.imem_req_valid;
      qr = bus.imem_req_ready;
      iv = bus.if_valid;
      ir = bus.if_ready;
      if (ex_redirect) begin
        chk("redir_if_valid", iv, 0);
        chk("redir_req_valid", qv, 0);
      end
      if (chk_lat && !ex_redirect) begin
        chk("redir_lat_valid", qv, 1);
        chk("redir_lat_addr", bus.imem_req_addr, lat_tgt);
      end
      if (hold_chk && !ex_redirect) begin
        chk("hold_valid", iv, 1);
        chk("hold_pc", bus.if_pc, hold_pc);
        chk("hold_inst", bus.if_inst, hold_inst);
      end
      if (iv && ir) begin
        chk("if_pc", bus.if_pc, exp_pc);
        chk("if_inst", bus.if_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliv++;
      end
      hold_chk  = iv && !ir;
      hold_pc   = bus.if_pc;
      hold_inst = bus.if_inst;
      if (rv && rr) pend = 1'b0;
      else if (pend && dly > 0) dly--;
      if (qv && qr) begin
        chk("one_outstanding", pend, 0);
        chk("req_addr", bus.imem_req_addr, exp_pc);
        pend      = 1'b1;
        dly       = $urandom_range(lat_max);
        pend_addr = bus.imem_req_addr;
      end
      chk_lat = 1'b0;
      if (ex_redirect) begin
        exp_pc  = {ex_redirect_pc[31:1], 1'b0};
        lat_tgt = exp_pc;
        chk_lat = !(rr && !rv);
      end
`ifdef CORE_IF_REDIRECT_CNT_EN
      chk("redirect_cnt", cnt, cnt_m);
      if (ex_redirect) cnt_m = cnt_m + 32'd1;
`endif
    end
  endtask

  initial begin
    rst                 = 1'b1;
    rst2                = 1'b1;
    ex_redirect         = 1'b0;
    ex_redirect_pc      = '0;
    ex_redirect2        = 1'b0;
    ex_redirect_pc2     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_inst   = '0;
    bus.if_ready        = 1'b0;
    bus2.imem_req_ready = 1'b0;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_inst  = '0;
    bus2.if_ready       = 1'b0;
    deliv               = 0;
    model_reset();

    // zero-wait memory, decode always ready: 1 instr / 3 cycles
    do_reset();
    p_rdy = 100; lat_max = 0; p_ifr = 100; p_redir = 0;
    deliv = 0;
    run(30);
    chk("throughput", deliv, 10);

    // random stalls, latencies and redirects
    p_rdy = 60; lat_max = 3; p_ifr = 60; p_redir = 10;
    run(2000);
    do_reset();
    p_rdy = 80; lat_max = 2; p_ifr = 40; p_redir = 30;
    run(2000);
    do_reset();
    p_rdy = 100; lat_max = 0; p_ifr = 100; p_redir = 15;
    run(1000);

    // wrapping reset PC and async reset mid-fetch
    @(negedge clk);
    chk("r2_req_in_rst", bus2.imem_req_valid, 0);
    chk("r2_if_pc_rst", bus2.if_pc, 0);
    bus2.imem_req_ready = 1'b1;
    rst2 = 1'b0;
    #1;
    chk("r2_req_valid0", bus2.imem_req_valid, 1);
    chk("r2_req_addr0", bus2.imem_req_addr, RST_PC2);
    @(posedge clk);
    #2;
    chk("r2_rsp_ready", bus2.imem_rsp_ready, 1);
    bus2.imem_rsp_valid = 1'b1;
    bus2.imem_rsp_inst  = 32'h1234_5678;
    @(posedge clk);
    #2;
    bus2.imem_rsp_valid = 1'b0;
    chk("r2_if_valid", bus2.if_valid, 1);
    chk("r2_if_pc", bus2.if_pc, RST_PC2);
    chk("r2_if_inst", bus2.if_inst, 32'h1234_5678);
    chk("r2_no_req_out", bus2.imem_req_valid, 0);
    bus2.if_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("r2_req_valid1", bus2.imem_req_valid, 1);
    chk("r2_req_wrap", bus2.imem_req_addr, 0);
    @(posedge clk);
    #2;
    chk("r2_wait", bus2.imem_rsp_ready, 1);
    rst2 = 1'b1;
    #1;
    chk("r2_async_rsp", bus2.imem_rsp_ready, 0);
    chk("r2_async_req", bus2.imem_req_valid, 0);
    chk("r2_async_pc", bus2.if_pc, 0);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("r2_re_valid", bus2.imem_req_valid, 1);
    chk("r2_re_addr", bus2.imem_req_addr, RST_PC2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
